// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator.
// Next-PC priority: reset > trap > redirect > fire with return prediction >
// fire sequential > hold. Optional return-address stack built only when
// PC_GEN_RAS_EN is defined; otherwise hints are ignored and flags are constant.
module pc_gen #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            call_hint,
  input  logic            ret_hint,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_valid,
  output logic            misaligned,
  output logic            ras_empty,
  output logic            ras_full
);

  logic            fire;
  logic            redir_ok;
  logic            predict;
  logic [XLEN-1:0] predict_pc;
  logic [XLEN-1:0] pc_nxt;
  logic            warm;

  assign pc_plus4 = pc + XLEN'(4);
  assign fire     = pc_valid & fetch_ready & ~stall;
  assign redir_ok = redirect_valid & (redirect_pc[1:0] == 2'b00);

`ifdef PC_GEN_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  // sp points at the next free slot; the stack wraps so a push when full
  // silently overwrites the oldest entry.
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   sp;
  logic [PW-1:0]   top_idx;
  logic [PW:0]     cnt;
  logic            hint_ok;
  logic            do_call;
  logic            do_ret;

  // Hints only count on a fire with no trap or redirect competing for the PC.
  assign hint_ok    = fire & ~trap_valid & ~redirect_valid;
  assign do_call    = hint_ok & call_hint;
  assign do_ret     = hint_ok & ret_hint & (cnt != '0);
  assign top_idx    = sp - 1'b1;
  assign predict    = do_ret;
  assign predict_pc = ras_mem[top_idx];
  assign ras_empty  = (cnt == '0);
  assign ras_full   = (cnt == (PW+1)'(RAS_DEPTH));

  // Stack pointer and occupancy; trap empties the stack logically.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp  <= '0;
      cnt <= '0;
    end else if (trap_valid) begin
      cnt <= '0;
    end else if (do_call && !do_ret) begin
      sp <= sp + 1'b1;
      if (cnt != (PW+1)'(RAS_DEPTH)) cnt <= cnt + 1'b1;
    end else if (do_ret && !do_call) begin
      sp  <= sp - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end

  // Entry storage; a call+ret pair replaces the top in place.
  always_ff @(posedge clk) begin
    if (!reset && do_call) begin
      if (do_ret) ras_mem[top_idx] <= pc_plus4;
      else        ras_mem[sp]      <= pc_plus4;
    end
  end
`else
  logic unused_hints;
  assign unused_hints = call_hint ^ ret_hint;
  assign predict      = 1'b0;
  assign predict_pc   = '0;
  assign ras_empty    = 1'b1;
  assign ras_full     = 1'b0;
`endif

  // Next-PC selection in priority order.
  always_comb begin
    pc_nxt = pc;
    if (trap_valid)    pc_nxt = trap_vec;
    else if (redir_ok) pc_nxt = redirect_pc;
    else if (redirect_valid) pc_nxt = pc;
    else if (predict)  pc_nxt = predict_pc;
    else if (fire)     pc_nxt = pc_plus4;
  end

  // PC, two-stage valid warm-up, and the misaligned-redirect pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_VEC;
      warm       <= 1'b0;
      pc_valid   <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      pc         <= pc_nxt;
      warm       <= 1'b1;
      pc_valid   <= warm;
      misaligned <= ~trap_valid & redirect_valid & ~redir_ok;
    end
  end

endmodule
